// File: rtl/move_exec.sv
// move_exec: accepts tour commands, runs gyro calibration or a forward move, then pulses send_resp.
// Optional feature macro MOVE_EXEC_FANFARE_EN: opcode 4'h5 moves like 4'h4 and fires fanfare_go with send_resp.
module move_exec #(
  parameter logic [9:0]  FRWRD_INC    = 10'h010,
  parameter logic [9:0]  FRWRD_MAX    = 10'h2A0,
  parameter int unsigned LINES_PER_SQ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic [11:0] dsrd_hdng,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare_go
);

  typedef enum logic [2:0] {IDLE, CAL, MOVE, RAMP_DN, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        pend_q, pend_d;
  logic [4:0]  line_cnt_q, line_cnt_d;
  logic        ir_q, rise_q;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] dsrd_hdng_q, dsrd_hdng_d;
  logic        clr_q, clr_d;
  logic        resp_q, resp_d;
  logic        cal_q, cal_d;
  logic        fan_q, fan_d;
  logic        moving_q, moving_d;

  logic [3:0]  opcode, squares;
  logic [7:0]  hdg;
  logic        is_move, is_fanfare;
  logic [4:0]  line_target;
  logic [10:0] frwrd_up, frwrd_dn_step;
  logic [9:0]  frwrd_inc_sat, frwrd_dec_flr;

  assign opcode  = cmd_q[15:12];
  assign hdg     = cmd_q[11:4];
  assign squares = cmd_q[3:0];

`ifdef MOVE_EXEC_FANFARE_EN
  assign is_move    = (opcode == 4'h4) || (opcode == 4'h5);
  assign is_fanfare = (opcode == 4'h5);
`else
  assign is_move    = (opcode == 4'h4);
  assign is_fanfare = 1'b0;
`endif

  assign line_target   = 5'(32'(squares) * LINES_PER_SQ);
  assign frwrd_up      = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
  assign frwrd_inc_sat = (frwrd_up > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_up[9:0];
  assign frwrd_dn_step = {FRWRD_INC, 1'b0};
  assign frwrd_dec_flr = ({1'b0, frwrd_q} <= frwrd_dn_step) ? 10'h000
                                                             : frwrd_q - frwrd_dn_step[9:0];

  // IDLE spends one cycle latching (and acking) the command, then decodes it from cmd_q.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pend_d      = 1'b0;
    line_cnt_d  = line_cnt_q;
    frwrd_d     = frwrd_q;
    dsrd_hdng_d = dsrd_hdng_q;
    clr_d       = 1'b0;
    resp_d      = 1'b0;
    cal_d       = 1'b0;
    fan_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (opcode == 4'h2) begin
            cal_d   = 1'b1;
            state_d = CAL;
          end else if (is_move && (squares != 4'h0)) begin
            dsrd_hdng_d = (hdg == 8'h00) ? 12'h000 : {hdg, 4'hF};
            line_cnt_d  = 5'd0;
            frwrd_d     = 10'h000;
            state_d     = MOVE;
          end else begin
            state_d = RESP;
          end
        end else if (cmd_rdy) begin
          cmd_d  = cmd;
          pend_d = 1'b1;
          clr_d  = 1'b1;
        end
      end
      CAL: begin
        if (cal_done) state_d = RESP;
      end
      MOVE: begin
        if (heading_rdy) frwrd_d = frwrd_inc_sat;
        if (rise_q) begin
          line_cnt_d = line_cnt_q + 5'd1;
          if (line_cnt_d == line_target) state_d = RAMP_DN;
        end
      end
      RAMP_DN: begin
        if (frwrd_q == 10'h000) state_d = RESP;
        else if (heading_rdy)   frwrd_d = frwrd_dec_flr;
      end
      RESP: begin
        resp_d  = 1'b1;
        fan_d   = is_fanfare;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    moving_d = (state_d == MOVE) || (state_d == RAMP_DN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= 16'h0000;
      pend_q      <= 1'b0;
      line_cnt_q  <= 5'd0;
      ir_q        <= 1'b0;
      rise_q      <= 1'b0;
      frwrd_q     <= 10'h000;
      dsrd_hdng_q <= 12'h000;
      clr_q       <= 1'b0;
      resp_q      <= 1'b0;
      cal_q       <= 1'b0;
      fan_q       <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pend_q      <= pend_d;
      line_cnt_q  <= line_cnt_d;
      ir_q        <= cntrIR;
      rise_q      <= cntrIR & ~ir_q;
      frwrd_q     <= frwrd_d;
      dsrd_hdng_q <= dsrd_hdng_d;
      clr_q       <= clr_d;
      resp_q      <= resp_d;
      cal_q       <= cal_d;
      fan_q       <= fan_d;
      moving_q    <= moving_d;
    end
  end

  assign clr_cmd_rdy = clr_q;
  assign send_resp   = resp_q;
  assign strt_cal    = cal_q;
  assign fanfare_go  = fan_q;
  assign dsrd_hdng   = dsrd_hdng_q;
  assign frwrd       = frwrd_q;
  assign moving      = moving_q;

endmodule

// File: tb/tb_move_exec.sv
// Self-checking bench for move_exec: directed and randomized commands against a transaction-level model.
module tb_move_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        heading_rdy;
  logic        cntrIR;
  logic        cal_done;
  logic        strt_cal;
  logic [11:0] dsrd_hdng;
  logic [9:0]  frwrd;
  logic        moving;
  logic        fanfare_go;

  int checks   = 0;
  int errors   = 0;
  int resp_cnt = 0;
  int clr_cnt  = 0;
  int cal_cnt  = 0;
  int fan_cnt  = 0;
  int fan_solo = 0;
  logic [11:0] last_hdng;

  move_exec dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .heading_rdy(heading_rdy),
    .cntrIR(cntrIR), .cal_done(cal_done), .strt_cal(strt_cal),
    .dsrd_hdng(dsrd_hdng), .frwrd(frwrd), .moving(moving), .fanfare_go(fanfare_go)
  );

  always #5 clk = ~clk;

  // Pulse counters see the value held through the cycle that ends at each rising edge.
  always @(posedge clk) begin
    if (send_resp === 1'b1)   resp_cnt++;
    if (clr_cmd_rdy === 1'b1) clr_cnt++;
    if (strt_cal === 1'b1)    cal_cnt++;
    if (fanfare_go === 1'b1)  fan_cnt++;
    if (fanfare_go === 1'b1 && send_resp !== 1'b1) fan_solo++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int hdgModel(input int h);
    return (h == 0) ? 0 : h * 16 + 15;
  endfunction

  function automatic int rampUp(input int v);
    return (v + 16 > 672) ? 672 : v + 16;
  endfunction

  function automatic int rampDown(input int v);
    return (v > 32) ? v - 32 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a command for one cycle, checks the one-cycle ack, then scrambles cmd.
  task automatic applyStimulus(input logic [15:0] c);
    cmd     = c;
    cmd_rdy = 1'b1;
    tick(1);
    checkOutput("ack", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    cmd     = 16'($urandom);
    tick(1);
    checkOutput("ack_pulse", clr_cmd_rdy, 0);
  endtask

  task automatic headingTick();
    heading_rdy = 1'b1;
    tick(1);
    heading_rdy = 1'b0;
    tick(1);
  endtask

  task automatic irPulse();
    cntrIR = 1'b1;
    tick(2);
    cntrIR = 1'b0;
    tick(2);
  endtask

  task automatic runMove(input logic [3:0] op, input logic [7:0] h, input logic [3:0] sq, input int k);
    int v;
    int r0;
    r0 = resp_cnt;
    applyStimulus({op, h, sq});
    tick(1);
    checkOutput("move_moving", moving, 1);
    checkOutput("move_hdng", dsrd_hdng, hdgModel(int'(h)));
    checkOutput("move_frwrd0", frwrd, 0);
    last_hdng = 12'(hdgModel(int'(h)));
    v = 0;
    repeat (k) begin
      headingTick();
      v = rampUp(v);
    end
    checkOutput("ramp_up", frwrd, v);
    repeat (2 * int'(sq) - 1) irPulse();
    headingTick();
    v = rampUp(v);
    checkOutput("pre_last_line", frwrd, v);
    irPulse();
    checkOutput("hold_after_lines", frwrd, v);
    checkOutput("no_early_resp", resp_cnt, r0);
    while (v > 0) begin
      headingTick();
      v = rampDown(v);
      checkOutput("ramp_dn", frwrd, v);
    end
    tick(6);
    checkOutput("resp_once", resp_cnt, r0 + 1);
    checkOutput("move_done_moving", moving, 0);
    checkOutput("move_done_frwrd", frwrd, 0);
  endtask

  task automatic noMotion(input logic [15:0] c);
    int r0;
    r0 = resp_cnt;
    applyStimulus(c);
    checkOutput("nm_resp_early", send_resp, 0);
    tick(1);
    checkOutput("nm_resp_2cyc", send_resp, 1);
    tick(1);
    checkOutput("nm_resp_pulse", send_resp, 0);
    checkOutput("nm_resp_cnt", resp_cnt, r0 + 1);
    checkOutput("nm_frwrd", frwrd, 0);
    checkOutput("nm_moving", moving, 0);
    checkOutput("nm_hdng_hold", dsrd_hdng, last_hdng);
    tick(2);
  endtask

  initial begin
    int s0, r0, c0, n;
    logic [3:0] op;
    rst_n = 1'b0; cmd = 16'h0000; cmd_rdy = 1'b0;
    heading_rdy = 1'b0; cntrIR = 1'b0; cal_done = 1'b0;
    last_hdng = 12'h000;
    tick(3);
    checkOutput("rst_clr", clr_cmd_rdy, 0);
    checkOutput("rst_resp", send_resp, 0);
    checkOutput("rst_cal", strt_cal, 0);
    checkOutput("rst_fanfare", fanfare_go, 0);
    checkOutput("rst_moving", moving, 0);
    checkOutput("rst_frwrd", frwrd, 0);
    checkOutput("rst_hdng", dsrd_hdng, 0);
    rst_n = 1'b1;
    tick(2);

    runMove(4'h4, 8'h00, 4'h2, int'($urandom_range(1, 12)));
    runMove(4'h4, 8'hBF, 4'h1, 60);

    s0 = cal_cnt;
    r0 = resp_cnt;
    applyStimulus({4'h2, 12'($urandom)});
    tick(1);
    checkOutput("strt_cal", cal_cnt, s0 + 1);
    tick(int'($urandom_range(3, 10)));
    checkOutput("cal_wait_no_resp", resp_cnt, r0);
    cal_done = 1'b1;
    tick(1);
    cal_done = 1'b0;
    tick(3);
    checkOutput("cal_resp", resp_cnt, r0 + 1);
    checkOutput("cal_once", cal_cnt, s0 + 1);
    checkOutput("cal_no_motion", frwrd, 0);

    noMotion(16'h43F0);
    noMotion(16'hF123);
    op = 4'($urandom);
    if (op == 4'h2 || op == 4'h4 || op == 4'h5) op = 4'hF;
    noMotion({op, 12'($urandom)});
    noMotion({4'h4, 8'($urandom), 4'h0});

    repeat (3) runMove(4'h4, 8'($urandom), 4'($urandom_range(1, 4)), int'($urandom_range(1, 50)));

    c0 = clr_cnt;
    r0 = resp_cnt;
    cmd = 16'h4011;
    cmd_rdy = 1'b1;
    tick(1);
    checkOutput("held_ack", clr_cmd_rdy, 1);
    tick(1);
    headingTick();
    headingTick();
    irPulse();
    irPulse();
    headingTick();
    n = 0;
    while (resp_cnt == r0 && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput("held_resp_timeout", n < 50, 1);
    checkOutput("held_no_reack", clr_cnt, c0 + 1);
    tick(2);
    checkOutput("held_reack", clr_cnt, c0 + 2);
    cmd_rdy = 1'b0;
    last_hdng = 12'h01F;
    headingTick();
    headingTick();
    headingTick();
    checkOutput("pre_reset_frwrd", frwrd, 48);
    rst_n = 1'b0;
    cmd = 16'hF000;
    cmd_rdy = 1'b1;
    tick(1);
    checkOutput("midrst_frwrd", frwrd, 0);
    checkOutput("midrst_moving", moving, 0);
    checkOutput("midrst_hdng", dsrd_hdng, 0);
    checkOutput("midrst_clr", clr_cmd_rdy, 0);
    last_hdng = 12'h000;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checkOutput("reack_after_reset", clr_cmd_rdy, 1);
    cmd_rdy = 1'b0;
    tick(6);

`ifdef MOVE_EXEC_FANFARE_EN
    s0 = fan_cnt;
    runMove(4'h5, 8'h00, 4'h1, 3);
    checkOutput("fanfare_pulse", fan_cnt, s0 + 1);
`else
    noMotion(16'h5001);
    checkOutput("fanfare_off", fan_cnt, 0);
`endif
    checkOutput("fanfare_solo", fan_solo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
